led_level_meter: RTL and testbench
==================================

LED_LEVEL_METER -- requirements
Module: led_level_meter

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, meaning the system clock frequency in Hz.
REQ-002 SHALL have parameter HOLD_MS, default 500, meaning the peak-hold time in ms (range 1..1023).
REQ-003 SHALL have parameter DECAY_MS, default 40, meaning the time per one-LED decay step in ms (range 1..255).
REQ-004 SHALL have port clk, input, 1 bit: the system clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port sample_valid, input, 1 bit: a one-cycle strobe marking a new sample; may be tied high.
REQ-007 SHALL have port sample, input, 8 bits: a thermometer-coded microphone level (bit k set means level > k).
REQ-008 SHALL have port led, output, 8 bits: the bar plus peak-dot display, registered.
REQ-009 SHALL have port bar_level, output, 4 bits: the current bar height, 0..8.
REQ-010 SHALL have port peak_level, output, 4 bits: the current peak position, 0..8.

Function
REQ-011 SHALL decode sample to level L = (index of highest set bit)+1, or 0 when sample==0; non-thermometer codes use the highest set bit only.
REQ-012 SHALL generate a 1 ms tick: a one-cycle pulse every CLK_HZ/1000 clocks from a free-running prescaler cleared by rst.
REQ-013 SHALL apply bar attack: on sample_valid with L >= bar, bar <= L in the next cycle.
REQ-014 SHALL apply bar decay: the decay counter counts ms ticks; every DECAY_MS ticks, if bar > 0 and no attack occurs that cycle, bar <= bar-1; it is never below 0.
REQ-015 SHALL give attack priority: attack on the same cycle as a decay step wins, and the decay step is dropped.
REQ-016 SHALL implement the peak FSM with states IDLE (peak=0), HOLD and FALL.
REQ-017 SHALL make the peak FSM transition IDLE->HOLD on sample_valid with L>0, loading peak<=L and hold_cnt<=HOLD_MS.
REQ-018 SHALL make the peak FSM handle HOLD: on sample_valid with L>peak, peak<=L and hold_cnt reloaded; L==peak also reloads hold_cnt; otherwise hold_cnt decrements per ms tick; at hold_cnt==0, go to FALL.
REQ-019 SHALL make the peak FSM handle FALL: peak decrements on each decay step; on sample_valid with L>=peak, peak<=L and go to HOLD (reload); when peak<=bar after decrement, go to HOLD with reload if bar>0, else IDLE.
REQ-020 SHALL keep peak_level >= bar_level at all times; if they would differ otherwise, peak is forced to bar.
REQ-021 SHALL drive the LED map led[i] = (i < bar) OR (peak>0 AND i == peak-1), registered from the current bar/peak, giving 1 cycle of latency after a bar/peak update.
REQ-022 SHALL ignore sample when sample_valid is 0, with no attack and no hold reload.
REQ-023 SHALL size all counters from parameters with no wrap: the prescaler holds CLK_HZ/1000-1, hold_cnt holds HOLD_MS, and the decay counter holds DECAY_MS-1.

Reset
REQ-024 SHALL, on rst, set led=0, bar_level=0, peak_level=0, FSM=IDLE, and the prescaler, hold and decay counters to 0, all in the next cycle.
REQ-025 SHALL let rst asserted mid-HOLD/FALL override all other events in that cycle; with rst held, outputs stay 0 regardless of sample_valid.

Structure
REQ-026 SHALL place the peak FSM state enum and the constant LEVEL_W=4 in the shared audio package, alongside the sample-width constant used by the microphone front end.
REQ-027 SHALL instantiate the 1 ms prescaler as sub-module ms_tick_gen (params CLK_HZ; ports clk, rst, tick); the rest is in led_level_meter.

Verification
REQ-028 SHALL verify attack/output: CLK_HZ=2000 (tick every 2 clks), HOLD_MS=4, DECAY_MS=2, and one valid with sample=8'h1F -> bar_level=5, peak_level=5, led=8'h1F one cycle later.
REQ-029 SHALL verify decay/hold: after REQ-028, sample=8'h00 held valid -> bar drops by 1 every 4 clks to 0; peak stays 5 for 8 clks (HOLD), then falls to meet the bar; led shows bar plus dot at bit 4 (e.g. 8'h17 when bar=3) during the hold.
REQ-030 SHALL verify hold reload: peak=5 in HOLD, valid sample=8'h1F at hold_cnt=1 -> hold_cnt reloads to 4 and peak is not lowered.
REQ-031 SHALL verify simultaneous events: an attack L=3 on the same cycle as a decay step with bar=3 -> bar stays 3, not 2.
REQ-032 SHALL verify non-thermometer and extreme inputs: sample=8'h81 -> L=8, led=8'hFF; sample=8'h00 from reset -> led=0, FSM stays IDLE.
REQ-033 SHALL verify reset mid-operation: rst asserted for 1 cycle while in FALL with peak=6 -> next cycle all outputs 0, FSM IDLE; first valid sample=8'h03 afterwards -> bar=2, peak=2.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio definitions: sample/level widths, peak FSM states and level helpers.
package audio_pkg;

    localparam int unsigned SAMPLE_W = 8;
    localparam int unsigned LEVEL_W  = 4;

    typedef enum logic [1:0] {
        PK_IDLE = 2'd0,
        PK_HOLD = 2'd1,
        PK_FALL = 2'd2
    } peak_state_t;

    // Level is one plus the index of the highest set bit; stray lower bits are ignored.
    function automatic logic [LEVEL_W-1:0] level_of(input logic [SAMPLE_W-1:0] s);
        logic [LEVEL_W-1:0] l;
        l = '0;
        for (int i = 0; i < SAMPLE_W; i++) begin
            if (s[i]) l = LEVEL_W'(i + 1);
        end
        return l;
    endfunction

    function automatic logic [LEVEL_W-1:0] lvl_max(input logic [LEVEL_W-1:0] a,
                                                  input logic [LEVEL_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Bar of height bar plus a single dot at position peak-1.
    function automatic logic [SAMPLE_W-1:0] led_map(input logic [LEVEL_W-1:0] bar,
                                                   input logic [LEVEL_W-1:0] peak);
        logic [SAMPLE_W-1:0] m;
        m = '0;
        for (int i = 0; i < SAMPLE_W; i++) begin
            m[i] = (LEVEL_W'(i) < bar) || ((peak != '0) && (LEVEL_W'(i + 1) == peak));
        end
        return m;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running prescaler producing a one-cycle pulse every millisecond.
module ms_tick_gen #(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned DIV      = (CLK_HZ / 1000 > 1) ? CLK_HZ / 1000 : 1;
    localparam int unsigned CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Count 0..DIV-1 and flag the terminal count as a registered tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == CNT_LAST);
            cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_level_meter.sv
// 8-LED level meter: fast-attack/slow-decay bar with a peak-hold dot.
module led_level_meter
    import audio_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned HOLD_MS  = 500,
    parameter int unsigned DECAY_MS = 40
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    output logic [SAMPLE_W-1:0] led,
    output logic [LEVEL_W-1:0]  bar_level,
    output logic [LEVEL_W-1:0]  peak_level
);

    localparam int unsigned HOLD_W  = $clog2(HOLD_MS + 1);
    localparam int unsigned DECAY_W = (DECAY_MS > 1) ? $clog2(DECAY_MS) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_MS);
    localparam logic [DECAY_W-1:0] DECAY_LAST = DECAY_W'(DECAY_MS - 1);

    logic                tick;
    logic [DECAY_W-1:0]  decay_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    peak_state_t         state;
    logic [LEVEL_W-1:0]  level_c;
    logic                decay_step_c;
    logic                attack_c;
    logic [LEVEL_W-1:0]  bar_next_c;

    ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign level_c      = level_of(sample);
    assign decay_step_c = tick && (decay_cnt == DECAY_LAST);
    assign attack_c     = sample_valid && (level_c >= bar_level);

    // Decay timebase: one step every DECAY_MS ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            decay_cnt <= '0;
        end else if (tick) begin
            decay_cnt <= (decay_cnt == DECAY_LAST) ? '0 : decay_cnt + DECAY_W'(1);
        end
    end

    // Next bar height: attack beats a coincident decay step; never below zero.
    always_comb begin
        bar_next_c = bar_level;
        if (attack_c) begin
            bar_next_c = level_c;
        end else if (decay_step_c && (bar_level != '0)) begin
            bar_next_c = bar_level - LEVEL_W'(1);
        end
    end

    // Bar register.
    always_ff @(posedge clk) begin
        if (rst) bar_level <= '0;
        else     bar_level <= bar_next_c;
    end

    // Peak-hold FSM; every peak update is floored at the new bar height.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= PK_IDLE;
            peak_level <= '0;
            hold_cnt   <= '0;
        end else begin
            peak_level <= lvl_max(peak_level, bar_next_c);
            unique case (state)
                PK_IDLE: begin
                    if (sample_valid && (level_c != '0)) begin
                        state      <= PK_HOLD;
                        peak_level <= lvl_max(level_c, bar_next_c);
                        hold_cnt   <= HOLD_LOAD;
                    end
                end
                PK_HOLD: begin
                    if (sample_valid && (level_c >= peak_level)) begin
                        peak_level <= lvl_max(level_c, bar_next_c);
                        hold_cnt   <= HOLD_LOAD;
                    end else if (tick) begin
                        if (hold_cnt <= HOLD_W'(1)) begin
                            state    <= PK_FALL;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt - HOLD_W'(1);
                        end
                    end
                end
                PK_FALL: begin
                    if (sample_valid && (level_c >= peak_level)) begin
                        state      <= PK_HOLD;
                        peak_level <= lvl_max(level_c, bar_next_c);
                        hold_cnt   <= HOLD_LOAD;
                    end else if (decay_step_c) begin
                        // Compare as peak <= bar+1 so a zero peak cannot wrap.
                        if (peak_level <= bar_next_c + LEVEL_W'(1)) begin
                            peak_level <= bar_next_c;
                            if (bar_next_c != '0) begin
                                state    <= PK_HOLD;
                                hold_cnt <= HOLD_LOAD;
                            end else begin
                                state <= PK_IDLE;
                            end
                        end else begin
                            peak_level <= peak_level - LEVEL_W'(1);
                        end
                    end
                end
                default: state <= PK_IDLE;
            endcase
        end
    end

    // LED map registered from the current bar/peak registers.
    always_ff @(posedge clk) begin
        if (rst) led <= '0;
        else     led <= led_map(bar_level, peak_level);
    end

endmodule

// File: tb/tb_led_level_meter.sv
// Directed scoreboard bench for led_level_meter with a 2-clock ms tick.
module tb_led_level_meter;
    import audio_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_valid = 1'b0;
    logic [7:0] sample = 8'h00;
    logic [7:0] led;
    logic [3:0] bar_level;
    logic [3:0] peak_level;

    always #5 clk = ~clk;

    led_level_meter #(
        .CLK_HZ   (2000),
        .HOLD_MS  (4),
        .DECAY_MS (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample       (sample),
        .led          (led),
        .bar_level    (bar_level),
        .peak_level   (peak_level)
    );

    typedef struct {
        string      tag;
        int         due;
        logic [3:0] bar;
        logic [3:0] peak;
        logic [7:0] led;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_assert;
    int   n_fail;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_at(input int due, input string tag, input logic [3:0] b,
                             input logic [3:0] p, input logic [7:0] l);
        sb.push_back('{tag, due, b, p, l});
    endtask

    // Advance one clock, sample 1 time unit after the edge, retire due expectations.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            n_assert++;
            assert (e.due == cyc) else begin
                n_fail++;
                $error("FAIL %s.due: observed cycle %0d expected cycle %0d", e.tag, cyc, e.due);
            end
            check_val({e.tag, ".bar"},  8'(bar_level),  8'(e.bar));
            check_val({e.tag, ".peak"}, 8'(peak_level), 8'(e.peak));
            check_val({e.tag, ".led"},  led,            e.led);
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Reset held two cycles with a loud valid sample present; outputs must stay 0.
    task automatic do_reset(input string tag);
        rst          = 1'b1;
        sample_valid = 1'b1;
        sample       = 8'hFF;
        step();
        step();
        check_val({tag, ".rst_bar"},   8'(bar_level),  8'h00);
        check_val({tag, ".rst_peak"},  8'(peak_level), 8'h00);
        check_val({tag, ".rst_led"},   led,            8'h00);
        check_val({tag, ".rst_state"}, 8'(dut.state),  8'(PK_IDLE));
        rst          = 1'b0;
        sample_valid = 1'b0;
        sample       = 8'h00;
        cyc          = 0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        cyc      = 0;

        // Attack to 5, then decay with hold and fall of the peak.
        do_reset("a");
        sample_valid = 1'b1;
        sample       = 8'h1F;
        expect_at(1, "a_attack", 4'd5, 4'd5, 8'h00);
        step();
        sample = 8'h00;
        expect_at(2,  "a_led",    4'd5, 4'd5, 8'h1F);
        expect_at(6,  "a_dec1",   4'd4, 4'd5, 8'h1F);
        expect_at(8,  "a_hold",   4'd4, 4'd5, 8'h1F);
        run(8);
        check_val("a_fall_state", 8'(dut.state), 8'(PK_FALL));
        expect_at(10, "a_dot",    4'd3, 4'd5, 8'h17);
        expect_at(14, "a_fall1",  4'd2, 4'd4, 8'h0B);
        expect_at(18, "a_fall2",  4'd1, 4'd3, 8'h05);
        expect_at(22, "a_fall3",  4'd0, 4'd2, 8'h02);
        expect_at(26, "a_fall4",  4'd0, 4'd1, 8'h01);
        expect_at(30, "a_empty",  4'd0, 4'd0, 8'h00);
        run(21);
        check_val("a_idle_state", 8'(dut.state), 8'(PK_IDLE));

        // Hold reload when a matching sample arrives at hold_cnt == 1.
        do_reset("b");
        sample_valid = 1'b1;
        sample       = 8'h1F;
        expect_at(1, "b_attack", 4'd5, 4'd5, 8'h00);
        step();
        sample_valid = 1'b0;
        sample       = 8'h00;
        run(6);
        check_val("b_hold_pre", 8'(dut.hold_cnt), 8'd1);
        sample_valid = 1'b1;
        sample       = 8'h1F;
        expect_at(8, "b_reload", 4'd5, 4'd5, 8'h1F);
        step();
        check_val("b_hold_reload", 8'(dut.hold_cnt), 8'd4);
        sample_valid = 1'b0;
        sample       = 8'h00;
        expect_at(13, "b_held1", 4'd3, 4'd5, 8'h1F);
        expect_at(16, "b_held2", 4'd3, 4'd5, 8'h17);
        expect_at(17, "b_fall",  4'd2, 4'd4, 8'h17);
        expect_at(18, "b_led",   4'd2, 4'd4, 8'h0B);
        run(10);

        // Attack coinciding with a decay step keeps the bar.
        do_reset("c");
        sample_valid = 1'b1;
        sample       = 8'h07;
        expect_at(1, "c_attack", 4'd3, 4'd3, 8'h00);
        step();
        sample_valid = 1'b0;
        sample       = 8'h00;
        expect_at(4, "c_pre", 4'd3, 4'd3, 8'h07);
        run(3);
        sample_valid = 1'b1;
        sample       = 8'h07;
        expect_at(5, "c_tie", 4'd3, 4'd3, 8'h07);
        step();
        sample_valid = 1'b0;
        sample       = 8'h00;
        expect_at(9,  "c_decay", 4'd2, 4'd3, 8'h07);
        expect_at(10, "c_led",   4'd2, 4'd3, 8'h07);
        run(5);

        // Silence stays idle; non-thermometer code lights everything.
        do_reset("d");
        sample_valid = 1'b1;
        sample       = 8'h00;
        expect_at(4, "d_silent", 4'd0, 4'd0, 8'h00);
        run(4);
        check_val("d_idle_state", 8'(dut.state), 8'(PK_IDLE));
        sample = 8'h81;
        expect_at(5, "d_full", 4'd8, 4'd8, 8'h00);
        step();
        sample_valid = 1'b0;
        sample       = 8'h00;
        expect_at(6, "d_led", 4'd8, 4'd8, 8'hFF);
        step();

        // Reset asserted in FALL with peak 6, then a fresh small sample.
        do_reset("e");
        sample_valid = 1'b1;
        sample       = 8'h3F;
        expect_at(1, "e_attack", 4'd6, 4'd6, 8'h00);
        step();
        sample_valid = 1'b0;
        sample       = 8'h00;
        expect_at(9, "e_in_fall", 4'd4, 4'd6, 8'h3F);
        run(8);
        check_val("e_fall_state", 8'(dut.state), 8'(PK_FALL));
        rst          = 1'b1;
        sample_valid = 1'b1;
        sample       = 8'hFF;
        expect_at(10, "e_reset", 4'd0, 4'd0, 8'h00);
        step();
        check_val("e_reset_state", 8'(dut.state), 8'(PK_IDLE));
        rst    = 1'b0;
        sample = 8'h03;
        expect_at(11, "e_after", 4'd2, 4'd2, 8'h00);
        step();
        sample_valid = 1'b0;
        sample       = 8'h00;
        expect_at(12, "e_led", 4'd2, 4'd2, 8'h03);
        step();

        check_val("sb_drained", 8'(sb.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
